reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_if.sv | 52 +++++
 rtl/reorder_buffer.sv | 142 ++++++++++++++
 tb/tb_reorder_buffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle.
//   master : issue/writeback/query producer (front end, execution units, bench)
//   slave  : the reorder buffer itself
// Groups: issue (valid/rd/is_br/pred_taken/alt_pc -> stall/rob_id),
//         rename (set_dep_id/set_dep), writeback (wb_*), operand query (qry_*),
//         commit (set_value_*), flush (clear/clear_pc).
interface reorder_buffer_if #(parameter int ROB_INDEX_BIT = 3);
  logic                     issue_valid;
  logic [4:0]               issue_rd;
  logic                     issue_is_br;
  logic                     issue_pred_taken;
  logic [31:0]              issue_alt_pc;
  logic                     issue_stall;
  logic [ROB_INDEX_BIT-1:0] issue_rob_id;

  logic [4:0]               set_dep_id;
  logic [ROB_INDEX_BIT-1:0] set_dep;

  logic                     wb_valid;
  logic [ROB_INDEX_BIT-1:0] wb_rob_id;
  logic [31:0]              wb_value;
  logic                     wb_taken;

  logic [ROB_INDEX_BIT-1:0] qry_id1, qry_id2;
  logic                     qry_ready1, qry_ready2;
  logic [31:0]              qry_value1, qry_value2;

  logic [4:0]               set_value_id;
  logic [31:0]              set_value;
  logic [ROB_INDEX_BIT-1:0] set_value_rob_id;

  logic                     clear;
  logic [31:0]              clear_pc;

  modport master (
    output issue_valid, issue_rd, issue_is_br, issue_pred_taken, issue_alt_pc,
    input  issue_stall, issue_rob_id, set_dep_id, set_dep,
    output wb_valid, wb_rob_id, wb_value, wb_taken,
    output qry_id1, qry_id2,
    input  qry_ready1, qry_ready2, qry_value1, qry_value2,
    input  set_value_id, set_value, set_value_rob_id, clear, clear_pc
  );

  modport slave (
    input  issue_valid, issue_rd, issue_is_br, issue_pred_taken, issue_alt_pc,
    output issue_stall, issue_rob_id, set_dep_id, set_dep,
    input  wb_valid, wb_rob_id, wb_value, wb_taken,
    input  qry_id1, qry_id2,
    output qry_ready1, qry_ready2, qry_value1, qry_value2,
    output set_value_id, set_value, set_value_rob_id, clear, clear_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue of 2**ROB_INDEX_BIT in-flight instructions.
// Issues at tail, accepts out-of-order writebacks, retires in order from head
// (max one per cycle). A retiring mispredicted branch commits normally, drops
// every other entry and, one cycle later, pulses clear with the redirect PC.
// Ports:
//   clk_in  : clock
//   rst_in  : synchronous active-high reset
//   rdy_in  : global enable; all registered state frozen while low
//   rob     : reorder_buffer_if.slave bundle (issue, rename, wb, query, commit, flush)
module reorder_buffer #(
  parameter int ROB_INDEX_BIT = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  rob
);
  localparam int DEPTH = 1 << ROB_INDEX_BIT;
  localparam logic [ROB_INDEX_BIT:0] FULL = DEPTH[ROB_INDEX_BIT:0];

  typedef logic [ROB_INDEX_BIT-1:0] idx_t;

  logic [DEPTH-1:0]       busy, ready, is_br, pred_taken, taken;
  logic [DEPTH-1:0][4:0]  rd;
  logic [DEPTH-1:0][31:0] value, alt_pc;

  idx_t                   head, tail;
  logic [ROB_INDEX_BIT:0] count;
  logic                   flush_pend;
  logic [31:0]            flush_pc;

  logic [4:0]             sv_id_q;
  logic [31:0]            sv_val_q;
  idx_t                   sv_rob_q;
  logic                   clear_q;
  logic [31:0]            clear_pc_q;

  logic stall, issue_acc, wb_acc, retire, mispredict;

  // Stall comes from registered state only; a retire this cycle frees its
  // slot for the next cycle. The clear cycle also refuses issue since the
  // redirected front end has not delivered anything yet.
  assign stall = (count == FULL) || flush_pend || clear_q;

  always_comb begin
    issue_acc  = rdy_in && rob.issue_valid && !stall;
    wb_acc     = rdy_in && rob.wb_valid && !flush_pend && !clear_q && busy[rob.wb_rob_id];
    retire     = rdy_in && busy[head] && ready[head];
    mispredict = retire && is_br[head] && (taken[head] != pred_taken[head]);
  end

  assign rob.issue_stall      = stall;
  assign rob.issue_rob_id     = tail;
  assign rob.set_dep          = tail;
  assign rob.set_dep_id       = issue_acc ? rob.issue_rd : 5'd0;
  assign rob.set_value_id     = sv_id_q;
  assign rob.set_value        = sv_val_q;
  assign rob.set_value_rob_id = sv_rob_q;
  assign rob.clear            = clear_q;
  assign rob.clear_pc         = clear_pc_q;

  // Operand lookup with same-cycle writeback bypass.
  always_comb begin
    rob.qry_ready1 = busy[rob.qry_id1] && ready[rob.qry_id1];
    rob.qry_value1 = value[rob.qry_id1];
    rob.qry_ready2 = busy[rob.qry_id2] && ready[rob.qry_id2];
    rob.qry_value2 = value[rob.qry_id2];
    if (rob.wb_valid && rob.wb_rob_id == rob.qry_id1) begin
      rob.qry_ready1 = 1'b1;
      rob.qry_value1 = rob.wb_value;
    end
    if (rob.wb_valid && rob.wb_rob_id == rob.qry_id2) begin
      rob.qry_ready2 = 1'b1;
      rob.qry_value2 = rob.wb_value;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy       <= '0;
      ready      <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      flush_pend <= 1'b0;
      flush_pc   <= '0;
      sv_id_q    <= '0;
      sv_val_q   <= '0;
      sv_rob_q   <= '0;
      clear_q    <= 1'b0;
      clear_pc_q <= '0;
    end else if (rdy_in) begin
      // Commit outputs are a one-cycle pulse following each retire.
      sv_id_q  <= retire ? rd[head]    : 5'd0;
      sv_val_q <= retire ? value[head] : 32'd0;
      sv_rob_q <= retire ? head        : '0;

      // Flush is two-phase: commit cycle first, then the clear pulse.
      clear_q    <= flush_pend;
      clear_pc_q <= flush_pend ? flush_pc : 32'd0;
      if (flush_pend) flush_pend <= 1'b0;

      if (issue_acc) begin
        busy[tail]       <= 1'b1;
        ready[tail]      <= 1'b0;
        rd[tail]         <= rob.issue_rd;
        is_br[tail]      <= rob.issue_is_br;
        pred_taken[tail] <= rob.issue_pred_taken;
        alt_pc[tail]     <= rob.issue_alt_pc;
        tail             <= tail + 1'b1;
      end

      if (wb_acc) begin
        ready[rob.wb_rob_id] <= 1'b1;
        value[rob.wb_rob_id] <= rob.wb_value;
        taken[rob.wb_rob_id] <= rob.wb_taken;
      end

      if (retire) begin
        busy[head] <= 1'b0;
        head       <= head + 1'b1;
      end

      unique case ({issue_acc, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Placed last so it overrides any same-cycle issue/wb/retire updates.
      if (mispredict) begin
        busy       <= '0;
        ready      <= '0;
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        flush_pend <= 1'b1;
        flush_pc   <= alt_pc[head];
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic rdy_q  = 1'b0;

  int checks = 0;
  int errors = 0;

  reorder_buffer_if #(.ROB_INDEX_BIT(3)) bus ();

  reorder_buffer #(.ROB_INDEX_BIT(3)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .rob    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0] rd;
    logic [2:0] id;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  logic [31:0] exp_val [8];
  logic [2:0]  exp_tail;

  typedef struct {
    logic [2:0]  qid;
    logic        wbv;
    logic [2:0]  wbid;
    logic [31:0] wbval;
    logic        exp_rdy;
    logic [31:0] exp_v;
    logic        cv;
  } qv_t;

  qv_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Commit scoreboard: program-order queue filled at issue, drained here.
  always @(posedge clk_in) rdy_q <= rdy_in;

  always @(negedge clk_in) begin
    if (!rst_in && rdy_q && bus.set_value_id != 5'd0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got rd %0d expected none", bus.set_value_id);
      end else begin
        mon_e = sb.pop_front();
        chk("commit_rd",    32'(bus.set_value_id),     32'(mon_e.rd));
        chk("commit_id",    32'(bus.set_value_rob_id), 32'(mon_e.id));
        chk("commit_value", bus.set_value,             exp_val[mon_e.id]);
      end
    end
  end

  task automatic idle_inputs();
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_is_br = 1'b0;
    bus.issue_pred_taken = 1'b0; bus.issue_alt_pc = '0;
    bus.wb_valid = 1'b0; bus.wb_rob_id = '0; bus.wb_value = '0; bus.wb_taken = 1'b0;
    bus.qry_id1 = '0; bus.qry_id2 = '0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle_inputs();
    step();
    step();
    rst_in = 1'b0;
    sb.delete();
    exp_tail = 3'd0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic br, input logic pt, input logic [31:0] alt);
    bus.issue_valid = 1'b1; bus.issue_rd = rd; bus.issue_is_br = br;
    bus.issue_pred_taken = pt; bus.issue_alt_pc = alt;
    #1;
    chk("issue_stall",  32'(bus.issue_stall),  32'd0);
    chk("issue_rob_id", 32'(bus.issue_rob_id), 32'(exp_tail));
    chk("set_dep_id",   32'(bus.set_dep_id),   32'(rd));
    chk("set_dep",      32'(bus.set_dep),      32'(exp_tail));
    sb.push_back('{rd, exp_tail});
    exp_tail = exp_tail + 3'd1;
    step();
    bus.issue_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [2:0] id, input logic [31:0] val, input logic tk);
    bus.wb_valid = 1'b1; bus.wb_rob_id = id; bus.wb_value = val; bus.wb_taken = tk;
    exp_val[id] = val;
    step();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{3'd1, 1'b0, 3'd0, 32'h0,      1'b1, 32'h111,  1'b1};
    tbl[1] = '{3'd0, 1'b0, 3'd0, 32'h0,      1'b0, 32'h0,    1'b0};
    tbl[2] = '{3'd3, 1'b1, 3'd3, 32'hBEEF,   1'b1, 32'hBEEF, 1'b1};
    tbl[3] = '{3'd2, 1'b1, 3'd3, 32'hBEEF,   1'b0, 32'h0,    1'b0};
    tbl[4] = '{3'd1, 1'b1, 3'd1, 32'h999,    1'b1, 32'h999,  1'b1};
    tbl[5] = '{3'd5, 1'b0, 3'd0, 32'h0,      1'b0, 32'h0,    1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_issue_stall", 32'(bus.issue_stall),  32'd0);
    chk("rst_rob_id",      32'(bus.issue_rob_id), 32'd0);
    chk("rst_sv_id",       32'(bus.set_value_id), 32'd0);
    chk("rst_sv",          bus.set_value,         32'd0);
    chk("rst_clear",       32'(bus.clear),        32'd0);
    chk("rst_clear_pc",    bus.clear_pc,          32'd0);
    chk("rst_qry_ready",   32'(bus.qry_ready1),   32'd0);

    // Basic issue / wb / commit
    do_issue(5'd5, 1'b0, 1'b0, 32'h0);
    do_wb(3'd0, 32'h1234, 1'b0);
    step();
    chk("t1_sv_id",  32'(bus.set_value_id),     32'd5);
    chk("t1_sv",     bus.set_value,             32'h1234);
    chk("t1_sv_rob", 32'(bus.set_value_rob_id), 32'd0);
    step();
    chk("t1_sv_id_clr", 32'(bus.set_value_id), 32'd0);

    // Full buffer, stall, wrap
    do_reset();
    for (int i = 0; i < 8; i++) do_issue(5'(i + 1), 1'b0, 1'b0, 32'h0);
    chk("t2_full_stall", 32'(bus.issue_stall),  32'd1);
    chk("t2_full_tail",  32'(bus.issue_rob_id), 32'd0);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd30;
    #1;
    chk("t2_refused_dep", 32'(bus.set_dep_id), 32'd0);
    step();
    bus.issue_valid = 1'b0;
    do_wb(3'd0, 32'hA0, 1'b0);
    chk("t2_stall_same_cycle", 32'(bus.issue_stall), 32'd1);
    step();
    chk("t2_stall_freed", 32'(bus.issue_stall), 32'd0);
    do_issue(5'd9, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i < 8; i++) do_wb(3'(i), 32'hA0 + 32'(i), 1'b0);
    do_wb(3'd0, 32'hB0, 1'b0);
    repeat (12) step();
    chk("t2_drained", 32'(sb.size()), 32'd0);

    // Out-of-order writeback, in-order retire
    do_reset();
    for (int i = 0; i < 3; i++) do_issue(5'(10 + i), 1'b0, 1'b0, 32'h0);
    do_wb(3'd2, 32'h22, 1'b0);
    do_wb(3'd0, 32'h20, 1'b0);
    repeat (3) step();
    chk("t3_pending", 32'(sb.size()), 32'd2);
    do_wb(3'd1, 32'h21, 1'b0);
    step();
    chk("t3_first",  32'(bus.set_value_rob_id), 32'd1);
    step();
    chk("t3_second", 32'(bus.set_value_rob_id), 32'd2);
    repeat (3) step();
    chk("t3_drained", 32'(sb.size()), 32'd0);

    // Branch mispredict flush
    do_reset();
    do_issue(5'd3, 1'b1, 1'b0, 32'h100);
    do_issue(5'd4, 1'b0, 1'b0, 32'h0);
    do_wb(3'd0, 32'h55, 1'b1);
    step();
    chk("t4_commit_rd", 32'(bus.set_value_id), 32'd3);
    chk("t4_clear_lo",  32'(bus.clear),        32'd0);
    chk("t4_stall_a",   32'(bus.issue_stall),  32'd1);
    void'(sb.pop_back());
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    bus.wb_valid = 1'b1; bus.wb_rob_id = 3'd1; bus.wb_value = 32'hDEAD;
    #1;
    chk("t4_dep_blocked", 32'(bus.set_dep_id), 32'd0);
    step();
    chk("t4_clear_hi",  32'(bus.clear),        32'd1);
    chk("t4_clear_pc",  bus.clear_pc,          32'h100);
    chk("t4_stall_b",   32'(bus.issue_stall),  32'd1);
    chk("t4_sv_clr",    32'(bus.set_value_id), 32'd0);
    step();
    bus.issue_valid = 1'b0; bus.wb_valid = 1'b0; bus.qry_id1 = 3'd1;
    #1;
    chk("t4_clear_done", 32'(bus.clear),       32'd0);
    chk("t4_stall_done", 32'(bus.issue_stall), 32'd0);
    chk("t4_wb_ignored", 32'(bus.qry_ready1),  32'd0);
    exp_tail = 3'd0;
    do_issue(5'd6, 1'b0, 1'b0, 32'h0);
    do_wb(3'd0, 32'h66, 1'b0);
    repeat (3) step();
    chk("t4_drained", 32'(sb.size()), 32'd0);

    // Operand query table (state frozen so only combinational paths move)
    do_reset();
    for (int i = 0; i < 4; i++) do_issue(5'(i + 1), 1'b0, 1'b0, 32'h0);
    do_wb(3'd1, 32'h111, 1'b0);
    rdy_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.qry_id1 = tbl[i].qid; bus.qry_id2 = tbl[i].qid;
      bus.wb_valid = tbl[i].wbv; bus.wb_rob_id = tbl[i].wbid; bus.wb_value = tbl[i].wbval;
      #1;
      chk($sformatf("qry_ready1_%0d", i), 32'(bus.qry_ready1), 32'(tbl[i].exp_rdy));
      chk($sformatf("qry_ready2_%0d", i), 32'(bus.qry_ready2), 32'(tbl[i].exp_rdy));
      if (tbl[i].cv) chk($sformatf("qry_value1_%0d", i), bus.qry_value1, tbl[i].exp_v);
      bus.wb_valid = 1'b0;
      #1;
    end
    step();
    rdy_in = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_rob_id = 3'd3; bus.wb_value = 32'hBEEF; bus.qry_id1 = 3'd3;
    exp_val[3] = 32'hBEEF;
    #1;
    chk("t5_bypass_rdy", 32'(bus.qry_ready1), 32'd1);
    chk("t5_bypass_val", bus.qry_value1,      32'hBEEF);
    step();
    bus.wb_valid = 1'b0;
    #1;
    chk("t5_stored_rdy", 32'(bus.qry_ready1), 32'd1);
    chk("t5_stored_val", bus.qry_value1,      32'hBEEF);

    // Stall with a ready head
    do_wb(3'd0, 32'h100, 1'b0);
    step();
    chk("t6_sv_id", 32'(bus.set_value_id), 32'd1);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_hold_id_%0d", i),  32'(bus.set_value_id), 32'd1);
      chk($sformatf("t6_hold_val_%0d", i), bus.set_value,         32'h100);
    end
    rdy_in = 1'b1;
    step();
    chk("t6_resume_id",  32'(bus.set_value_id),     32'd2);
    chk("t6_resume_val", bus.set_value,             32'h111);
    chk("t6_resume_rob", 32'(bus.set_value_rob_id), 32'd1);
    do_wb(3'd2, 32'h222, 1'b0);
    repeat (5) step();
    chk("t6_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
